// File: rtl/main_fsm_pkg.sv
// Shared control encodings for the multicycle RISC-V controller.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [6:0] OP_LW        = 7'b0000011;
    localparam logic [6:0] OP_SW        = 7'b0100011;
    localparam logic [6:0] OP_RTYPE     = 7'b0110011;
    localparam logic [6:0] OP_ITYPE_ALU = 7'b0010011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_BEQ       = 7'b1100011;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM and the datapath/ALU decoder.
interface main_fsm_if;
    import main_fsm_pkg::*;

    logic [6:0] op;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        output op, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        input  ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal, state_o
    );

    modport slave (
        input  op, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        output ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal, state_o
    );

endinterface

// File: rtl/main_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.slave  bus
);

    state_t state;
    state_t next;
    logic   pc_update;
    logic   branch;
    logic   illegal_d;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    always_comb begin
        next      = S_FETCH;
        illegal_d = 1'b0;
        case (state)
            S_FETCH:  next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXECR;
                    OP_ITYPE_ALU: next = S_EXECI;
                    OP_JAL:       next = S_JAL;
                    OP_BEQ:       next = S_BEQ;
                    default: begin
                        next      = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      next = S_MEMREAD;
                else if (bus.op == OP_SW) next = S_MEMWRITE;
                else                      next = S_FETCH;
            end
            S_MEMREAD: next = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:     next = S_ALUWB;
            default:   next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RD2;
        bus.ALUOp     = ALUOP_ADD;
        bus.RegWrite  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                pc_update     = 1'b1;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: bus.RegWrite = 1'b1;
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_update   = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUOp   = ALUOP_SUB;
                branch      = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides: no writes, selects parked at their FETCH values.
        if (reset) begin
            pc_update     = 1'b0;
            branch        = 1'b0;
            bus.AdrSrc    = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.ResultSrc = RES_ALURES;
            bus.ALUSrcA   = SRCA_PC;
            bus.ALUSrcB   = SRCB_FOUR;
            bus.ALUOp     = ALUOP_ADD;
        end
    end

    assign bus.PCWrite = (branch & bus.zero) | pc_update;
    assign bus.illegal = illegal_d & ~reset;
    assign bus.state_o = reset ? 4'd0 : state;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm with an instruction-level reference model.
module tb_main_fsm;
    import main_fsm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    main_fsm_if bus ();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [13:0] dut_vec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite,
                           bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                           bus.ALUSrcB, bus.ALUOp, bus.RegWrite,
                           bus.illegal};

    // {PCUpdate, Branch, AdrSrc, MemWrite, IRWrite, ResultSrc,
    //  ALUSrcA, ALUSrcB, ALUOp, RegWrite} per state
    function automatic logic [13:0] tab(input int s);
        case (s)
            0:  return 14'b1_0_0_0_1_10_00_10_00_0;
            1:  return 14'b0_0_0_0_0_00_01_01_00_0;
            2:  return 14'b0_0_0_0_0_00_10_01_00_0;
            3:  return 14'b0_0_1_0_0_00_00_00_00_0;
            4:  return 14'b0_0_0_0_0_01_00_00_00_1;
            5:  return 14'b0_0_1_1_0_00_00_00_00_0;
            6:  return 14'b0_0_0_0_0_00_10_00_10_0;
            7:  return 14'b0_0_0_0_0_00_00_00_00_1;
            8:  return 14'b0_0_0_0_0_00_10_01_10_0;
            9:  return 14'b1_0_0_0_0_00_01_10_00_0;
            10: return 14'b0_1_0_0_0_00_10_00_01_0;
            default: return 14'b0;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE_ALU,
                          OP_JAL, OP_BEQ};
    endfunction

    function automatic logic [13:0] exp_vec(input int s, input logic z,
                                            input logic [6:0] op);
        logic [13:0] t;
        logic        pcw;
        logic        ill;
        t   = tab(s);
        pcw = t[13] | (t[12] & z);
        ill = (s == 1) && !legal(op);
        return {pcw, t[11:0], ill};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference path through the state graph for one instruction.
    task automatic model_seq(input logic [6:0] op, output int n,
                             output int seq[6]);
        seq = '{0, 1, 0, 0, 0, 0};
        n   = 2;
        case (op)
            OP_LW:        begin seq = '{0, 1, 2, 3, 4, 0}; n = 5; end
            OP_SW:        begin seq = '{0, 1, 2, 5, 0, 0}; n = 4; end
            OP_RTYPE:     begin seq = '{0, 1, 6, 7, 0, 0}; n = 4; end
            OP_ITYPE_ALU: begin seq = '{0, 1, 8, 7, 0, 0}; n = 4; end
            OP_JAL:       begin seq = '{0, 1, 9, 7, 0, 0}; n = 4; end
            OP_BEQ:       begin seq = '{0, 1, 10, 0, 0, 0}; n = 3; end
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge that enters FETCH.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic z_other, input logic z_beq,
                             input int max_states,
                             output int regw, output int memw,
                             output int pcw, output int irw,
                             output int ill, output logic [1:0] first);
        int seq[6];
        int n;
        logic z;
        model_seq(op, n, seq);
        if (max_states < n) n = max_states;
        regw = 0; memw = 0; pcw = 0; irw = 0; ill = 0; first = 2'b00;
        for (int i = 0; i < n; i++) begin
            z        = (seq[i] == 10) ? z_beq : z_other;
            bus.op   = (seq[i] == 1 || seq[i] == 2) ? op : ~op;
            bus.zero = z;
            @(negedge clk);
            check({name, " state"}, 32'(bus.state_o), 32'(seq[i]));
            check({name, " outputs"}, 32'(dut_vec),
                  32'(exp_vec(seq[i], z, op)));
            regw += int'(bus.RegWrite);
            memw += int'(bus.MemWrite & bus.AdrSrc);
            pcw  += int'(bus.PCWrite);
            irw  += int'(bus.IRWrite);
            ill  += int'(bus.illegal);
            if (i == 0) first = {bus.IRWrite, bus.PCWrite};
            @(posedge clk);
            #1;
        end
    endtask

    int regw, memw, pcw, irw, ill;
    logic [1:0] first;

    initial begin
        reset    = 1'b1;
        bus.op   = 7'h00;
        bus.zero = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset state", 32'(bus.state_o), 32'd0);
        check("reset outputs", 32'(dut_vec), 32'b0_0_0_0_10_00_10_00_0_0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw", OP_LW, 1'b1, 1'b1, 9, regw, memw, pcw, irw, ill,
                  first);
        check("lw regwrite count", 32'(regw), 32'd1);
        check("lw irwrite count", 32'(irw), 32'd1);

        run_instr("sw", OP_SW, 1'b0, 1'b0, 9, regw, memw, pcw, irw, ill,
                  first);
        check("sw memwrite count", 32'(memw), 32'd1);
        check("sw regwrite count", 32'(regw), 32'd0);

        run_instr("beq_taken", OP_BEQ, 1'b1, 1'b1, 9, regw, memw, pcw,
                  irw, ill, first);
        check("beq taken pcwrite count", 32'(pcw), 32'd2);

        run_instr("beq_not_taken", OP_BEQ, 1'b1, 1'b0, 9, regw, memw, pcw,
                  irw, ill, first);
        check("beq not taken pcwrite count", 32'(pcw), 32'd1);

        run_instr("rtype", OP_RTYPE, 1'b0, 1'b0, 9, regw, memw, pcw, irw,
                  ill, first);
        check("rtype regwrite count", 32'(regw), 32'd1);

        run_instr("itype", OP_ITYPE_ALU, 1'b1, 1'b0, 9, regw, memw, pcw,
                  irw, ill, first);
        check("itype pcwrite count", 32'(pcw), 32'd1);

        run_instr("jal", OP_JAL, 1'b0, 1'b0, 9, regw, memw, pcw, irw, ill,
                  first);
        check("jal pcwrite count", 32'(pcw), 32'd2);

        run_instr("illegal", 7'b1111111, 1'b1, 1'b1, 9, regw, memw, pcw,
                  irw, ill, first);
        check("illegal pulse count", 32'(ill), 32'd1);
        check("illegal write enables", 32'(regw + memw), 32'd0);

        // Abort a load in MEMREAD with a synchronous reset.
        run_instr("lw_abort", OP_LW, 1'b0, 1'b0, 3, regw, memw, pcw, irw,
                  ill, first);
        bus.op = ~OP_LW;
        reset  = 1'b1;
        @(negedge clk);
        check("reset mid state", 32'(bus.state_o), 32'd0);
        check("reset mid outputs", 32'(dut_vec),
              32'b0_0_0_0_10_00_10_00_0_0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr("post_reset_sw", OP_SW, 1'b0, 1'b0, 9, regw, memw, pcw,
                  irw, ill, first);
        check("post reset irwrite/pcwrite", 32'(first), 32'b11);

        run_instr("final_lw", OP_LW, 1'b0, 1'b0, 9, regw, memw, pcw, irw,
                  ill, first);
        @(negedge clk);
        check("final return to fetch", 32'(bus.state_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
